// File: rtl/load_store_unit.sv
// MEM-stage load/store sequencer: one bus access per instruction,
// pipeline stalled from issue until the access completes or times out.
module load_store_unit #(
  parameter int WAIT_LIMIT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  ResultSrcM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        FaultM,
  output logic        TimeoutM
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] LastWait = 8'(WAIT_LIMIT - 1);

  state_t      state, stateNext;
  logic [7:0]  waitCount;
  logic [1:0]  offsetQ;
  logic [2:0]  funct3Q;
  logic        isLoadQ;
  logic        isStore, isLoad, access;
  logic        misaligned, badFunct3, fault, timeout;
  logic [3:0]  wstrbNext;
  logic [31:0] wdataNext, shifted, loadData;

  always_comb begin
    isStore = MemWriteM;
    isLoad  = (ResultSrcM == 2'b01) && !MemWriteM;
    access  = isStore || isLoad;
    misaligned = 1'b0;
    unique case (Funct3M[1:0])
      2'b01:   misaligned = ALUResultM[0];
      2'b10:   misaligned = |ALUResultM[1:0];
      default: misaligned = 1'b0;
    endcase
    if (isStore)
      badFunct3 = Funct3M > 3'b010;
    else
      badFunct3 = (Funct3M == 3'b011) || (Funct3M[2:1] == 2'b11);
    fault = access && (misaligned || badFunct3);
  end

  always_comb begin
    wstrbNext = 4'b0000;
    wdataNext = WriteDataM;
    unique case (Funct3M[1:0])
      2'b00: begin
        wstrbNext = 4'b0001 << ALUResultM[1:0];
        wdataNext = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        wstrbNext = ALUResultM[1] ? 4'b1100 : 4'b0011;
        wdataNext = {2{WriteDataM[15:0]}};
      end
      default: wstrbNext = 4'b1111;
    endcase
    if (!isStore) wstrbNext = 4'b0000;
  end

  // formatting uses the offset captured at issue, not the live address
  always_comb begin
    shifted  = dmem_rdata >> {offsetQ, 3'b000};
    loadData = dmem_rdata;
    unique case (funct3Q)
      3'b000:  loadData = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  loadData = {24'b0, shifted[7:0]};
      3'b001:  loadData = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  loadData = {16'b0, shifted[15:0]};
      default: loadData = dmem_rdata;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    StallM    = 1'b0;
    FaultM    = 1'b0;
    timeout   = 1'b0;
    unique case (state)
      IDLE: begin
        FaultM = fault;
        StallM = access && !fault;
        if (access && !fault) stateNext = BUSY;
      end
      BUSY: begin
        StallM  = 1'b1;
        timeout = !dmem_ack && (waitCount == LastWait);
        if (dmem_ack || timeout) stateNext = DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      waitCount  <= '0;
      offsetQ    <= '0;
      funct3Q    <= '0;
      isLoadQ    <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wstrb <= '0;
      dmem_wdata <= '0;
      ReadDataM  <= '0;
      TimeoutM   <= 1'b0;
    end else begin
      TimeoutM <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fault) begin
            ReadDataM <= '0;
          end else if (access) begin
            dmem_req   <= 1'b1;
            dmem_we    <= isStore;
            dmem_addr  <= {ALUResultM[31:2], 2'b00};
            dmem_wstrb <= wstrbNext;
            dmem_wdata <= wdataNext;
            waitCount  <= '0;
            offsetQ    <= ALUResultM[1:0];
            funct3Q    <= Funct3M;
            isLoadQ    <= isLoad;
            // store wins over a simultaneous load request, which then reads 0
            if (isStore && ResultSrcM == 2'b01) ReadDataM <= '0;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (isLoadQ) ReadDataM <= loadData;
          end else if (timeout) begin
            dmem_req <= 1'b0;
            TimeoutM <= 1'b1;
            if (isLoadQ) ReadDataM <= '0;
          end else begin
            waitCount <= waitCount + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized + directed bench for load_store_unit against a
// transaction-level reference model.
module tb_load_store_unit;

  localparam int WL = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  ResultSrcM = '0;
  logic        MemWriteM = 1'b0;
  logic [2:0]  Funct3M = '0;
  logic [31:0] ALUResultM = '0;
  logic [31:0] WriteDataM = '0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_ack = 1'b0;
  logic [31:0] ReadDataM;
  logic        StallM, FaultM, TimeoutM;

  int nChecks = 0;
  int nFails = 0;
  logic [31:0] rdModel = '0;

  load_store_unit #(.WAIT_LIMIT(WL)) dut (
    .clock(clock), .reset(reset),
    .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
    .Funct3M(Funct3M), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .ReadDataM(ReadDataM),
    .StallM(StallM), .FaultM(FaultM), .TimeoutM(TimeoutM)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fmtLoad(logic [2:0] f3, logic [31:0] a,
                                         logic [31:0] rd);
    int unsigned off;
    logic [31:0] b, h;
    off = a % 4;
    b = (rd >> (8 * off)) & 32'hFF;
    h = (rd >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd5:    return h;
      default: return rd;
    endcase
  endfunction

  function automatic bit isFault(bit we, logic [1:0] rs, logic [2:0] f3,
                                 logic [31:0] a);
    int unsigned lo;
    lo = a % 4;
    if (we)
      return f3 > 2 || (f3 == 1 && lo % 2 == 1) || (f3 == 2 && lo != 0);
    if (rs == 2'b01)
      return f3 == 3 || f3 >= 6 || ((f3 == 1 || f3 == 5) && lo % 2 == 1)
             || (f3 == 2 && lo != 0);
    return 1'b0;
  endfunction

  function automatic logic [31:0] expStrb(logic [2:0] f3, logic [31:0] a);
    if (f3 == 0) return 32'd1 << (a % 4);
    if (f3 == 1) return ((a % 4) >= 2) ? 32'd12 : 32'd3;
    return 32'd15;
  endfunction

  function automatic logic [31:0] expWdata(logic [2:0] f3, logic [31:0] wd);
    if (f3 == 0) return (wd & 32'hFF) * 32'h0101_0101;
    if (f3 == 1) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  // ackAt: BUSY cycle (1-based) carrying the ack; > WL means never
  task automatic doAccess(string nm, bit we, logic [1:0] rs, logic [2:0] f3,
                          logic [31:0] a, logic [31:0] wd, int ackAt,
                          logic [31:0] rd);
    bit acked;
    @(negedge clock);
    MemWriteM = we;
    ResultSrcM = rs;
    Funct3M = f3;
    ALUResultM = a;
    WriteDataM = wd;
    #1;
    if (!(we || rs == 2'b01)) begin
      check({nm, ".idleStall"}, 32'(StallM), 0);
      check({nm, ".idleFault"}, 32'(FaultM), 0);
      @(posedge clock); #1;
      check({nm, ".idleReq"}, 32'(dmem_req), 0);
      return;
    end
    if (isFault(we, rs, f3, a)) begin
      check({nm, ".fault"}, 32'(FaultM), 1);
      check({nm, ".faultStall"}, 32'(StallM), 0);
      @(posedge clock); #1;
      rdModel = '0;
      check({nm, ".faultReq"}, 32'(dmem_req), 0);
      check({nm, ".faultRd"}, ReadDataM, rdModel);
      return;
    end
    check({nm, ".issueStall"}, 32'(StallM), 1);
    check({nm, ".issueFault"}, 32'(FaultM), 0);
    @(posedge clock); #1;
    check({nm, ".req"}, 32'(dmem_req), 1);
    check({nm, ".addr"}, dmem_addr, a & 32'hFFFF_FFFC);
    check({nm, ".we"}, 32'(dmem_we), 32'(we));
    if (we) begin
      check({nm, ".wstrb"}, 32'(dmem_wstrb), expStrb(f3, a));
      check({nm, ".wdata"}, dmem_wdata, expWdata(f3, wd));
      if (rs == 2'b01) rdModel = '0;
    end
    acked = 1'b0;
    for (int c = 1; c <= WL; c++) begin
      @(negedge clock);
      MemWriteM = 1'b0;
      ResultSrcM = 2'b00;
      ALUResultM = $urandom;
      Funct3M = 3'($urandom);
      check({nm, ".busyStall"}, 32'(StallM), 1);
      check({nm, ".busyReq"}, 32'(dmem_req), 1);
      dmem_ack = (c == ackAt);
      dmem_rdata = dmem_ack ? rd : $urandom;
      @(posedge clock);
      if (dmem_ack) begin
        acked = 1'b1;
        break;
      end
    end
    #1;
    if (!we) rdModel = acked ? fmtLoad(f3, a, rd) : 32'd0;
    check({nm, ".doneReq"}, 32'(dmem_req), 0);
    check({nm, ".timeout"}, 32'(TimeoutM), acked ? 32'd0 : 32'd1);
    check({nm, ".rdata"}, ReadDataM, rdModel);
    check({nm, ".doneStall"}, 32'(StallM), 0);
    @(negedge clock);
    dmem_ack = 1'b0;
    @(posedge clock); #1;
    check({nm, ".toPulse"}, 32'(TimeoutM), 0);
    check({nm, ".idleReq"}, 32'(dmem_req), 0);
  endtask

  initial begin
    bit we;
    logic [1:0] rs;
    logic [2:0] f3;
    logic [31:0] a;

    repeat (2) @(posedge clock);
    #1;
    check("rst.req", 32'(dmem_req), 0);
    check("rst.we", 32'(dmem_we), 0);
    check("rst.addr", dmem_addr, 0);
    check("rst.wstrb", 32'(dmem_wstrb), 0);
    check("rst.wdata", dmem_wdata, 0);
    check("rst.rdata", ReadDataM, 0);
    check("rst.timeout", 32'(TimeoutM), 0);
    check("rst.stall", 32'(StallM), 0);
    check("rst.fault", 32'(FaultM), 0);
    @(negedge clock);
    reset = 1'b0;

    doAccess("lb1003", 0, 2'b01, 3'd0, 32'h1003, 0, 2, 32'h80AA_BBCC);
    check("lb1003.value", ReadDataM, 32'hFFFF_FF80);
    doAccess("sh2002", 1, 2'b00, 3'd1, 32'h2002, 32'h1234_ABCD, 1, 0);
    check("sh2002.keepRd", ReadDataM, 32'hFFFF_FF80);
    doAccess("lw3001", 0, 2'b01, 3'd2, 32'h3001, 0, 1, 0);
    doAccess("lhuTo", 0, 2'b01, 3'd5, 32'h4000, 0, WL + 1, 0);
    doAccess("lhuAck4", 0, 2'b01, 3'd5, 32'h4000, 0, WL, 32'hBEEF_8001);
    doAccess("lw10", 0, 2'b01, 3'd2, 32'h10, 0, 1, 32'h1111_2222);
    doAccess("lw14", 0, 2'b01, 3'd2, 32'h14, 0, 1, 32'h3333_4444);
    doAccess("bothSet", 1, 2'b01, 3'd2, 32'h20, 32'hCAFE_F00D, 1, 0);

    // reset while BUSY, then a stray ack
    @(negedge clock);
    MemWriteM = 1'b0;
    ResultSrcM = 2'b01;
    Funct3M = 3'd2;
    ALUResultM = 32'h500;
    @(posedge clock); #1;
    check("rstBusy.req", 32'(dmem_req), 1);
    @(negedge clock);
    ResultSrcM = 2'b00;
    reset = 1'b1;
    @(posedge clock); #1;
    rdModel = '0;
    check("rstBusy.reqLow", 32'(dmem_req), 0);
    check("rstBusy.rd", ReadDataM, rdModel);
    @(negedge clock);
    reset = 1'b0;
    dmem_ack = 1'b1;
    dmem_rdata = $urandom;
    @(posedge clock); #1;
    check("stray.req", 32'(dmem_req), 0);
    check("stray.rd", ReadDataM, rdModel);
    check("stray.stall", 32'(StallM), 0);
    @(negedge clock);
    dmem_ack = 1'b0;
    doAccess("afterRst", 0, 2'b01, 3'd4, 32'h601, 0, 1, 32'h0000_9A00);

    for (int i = 0; i < 60; i++) begin
      we = ($urandom_range(0, 2) == 0);
      rs = 2'($urandom);
      if (!we && $urandom_range(0, 3) != 0) rs = 2'b01;
      f3 = 3'($urandom);
      if ($urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 2));
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
      doAccess("rand", we, rs, f3, a, $urandom, $urandom_range(1, WL + 1),
               $urandom);
    end

    @(negedge clock);
    MemWriteM = 1'b0;
    ResultSrcM = 2'b00;
    @(posedge clock); #1;
    check("final.stall", 32'(StallM), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
